// File: rtl/scene_control_multi_if.sv
// rtl/scene_control_multi_if.sv - game-state bundle between game logic and the scene controller
interface scene_control_multi_if #(
  parameter int NUM_GHOSTS = 2,
  parameter int COORD_W    = 10,
  parameter int DOT_W      = 6,
  parameter int POWER_W    = 3
);
  // Inputs to the scene controller
  logic                          tick;
  logic                          enter;
  logic [COORD_W-1:0]            pac_x;
  logic [COORD_W-1:0]            pac_y;
  logic [NUM_GHOSTS*COORD_W-1:0] ghost_x;
  logic [NUM_GHOSTS*COORD_W-1:0] ghost_y;
  logic [POWER_W-1:0]            power_cnt;
  logic [DOT_W-1:0]              dot_cnt;

  // Outputs from the scene controller
  logic [2:0]                    scene;
  logic [2:0]                    lives;
  logic [NUM_GHOSTS-1:0]         ghost_eaten;
  logic                          respawn;
  logic                          new_game;

  // Game side: drives positions, counters and buttons, consumes scene/pulses
  modport master (
    output tick, enter, pac_x, pac_y, ghost_x, ghost_y, power_cnt, dot_cnt,
    input  scene, lives, ghost_eaten, respawn, new_game
  );

  // Scene controller side
  modport slave (
    input  tick, enter, pac_x, pac_y, ghost_x, ghost_y, power_cnt, dot_cnt,
    output scene, lives, ghost_eaten, respawn, new_game
  );
endinterface

// File: rtl/scene_control_multi.sv
// rtl/scene_control_multi.sv - start/play/win/lose/dying scene sequencer with lives and ghost collisions
module scene_control_multi #(
  parameter int NUM_GHOSTS  = 2,
  parameter int COORD_W     = 10,
  parameter int DOT_W       = 6,
  parameter int POWER_W     = 3,
  parameter int LIVES       = 3,
  parameter int DEATH_TICKS = 60
) (
  input  logic                  clk,
  input  logic                  rst,
  scene_control_multi_if.slave  bus
);

  localparam logic [2:0] SCENE_START = 3'd0;
  localparam logic [2:0] SCENE_PLAY  = 3'd1;
  localparam logic [2:0] SCENE_WIN   = 3'd2;
  localparam logic [2:0] SCENE_LOSE  = 3'd3;
  localparam logic [2:0] SCENE_DYING = 3'd4;

  localparam logic [2:0] LIVES_INIT  = 3'(LIVES);
  localparam logic [7:0] TIMER_LAST  = 8'(DEATH_TICKS - 1);

  // Registered state
  logic                  enter_q;
  logic [2:0]            scene_q;
  logic [2:0]            lives_q;
  logic [7:0]            timer_q;
  logic [NUM_GHOSTS-1:0] eaten_q;
  logic                  respawn_q;
  logic                  new_game_q;

  // Next-state values
  logic [2:0]            scene_d;
  logic [2:0]            lives_d;
  logic [7:0]            timer_d;
  logic [NUM_GHOSTS-1:0] eaten_d;
  logic                  respawn_d;
  logic                  new_game_d;

  // Decoded conditions
  logic                  enter_rise;
  logic [NUM_GHOSTS-1:0] hit;
  logic                  any_hit;
  logic                  powered;
  logic                  dots_clear;
  logic                  death_done;

  assign enter_rise = bus.enter & ~enter_q;
  assign any_hit    = |hit;
  assign powered    = (bus.power_cnt != '0);
  assign dots_clear = (bus.dot_cnt == '0);
  assign death_done = bus.tick && (timer_q == TIMER_LAST);

  assign bus.scene       = scene_q;
  assign bus.lives       = lives_q;
  assign bus.ghost_eaten = eaten_q;
  assign bus.respawn     = respawn_q;
  assign bus.new_game    = new_game_q;

  // Delay enter by one cycle so only a 0->1 transition advances a scene
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enter_q <= 1'b0;
    end else begin
      enter_q <= bus.enter;
    end
  end

  // Exact-coordinate collision test of pacman against every ghost channel
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_GHOSTS; i++) begin
      hit[i] = (bus.pac_x == bus.ghost_x[i*COORD_W +: COORD_W]) &&
               (bus.pac_y == bus.ghost_y[i*COORD_W +: COORD_W]);
    end
  end

  // Scene transition logic; pulses default low so they last exactly one cycle
  always_comb begin
    scene_d    = scene_q;
    lives_d    = lives_q;
    timer_d    = timer_q;
    eaten_d    = '0;
    respawn_d  = 1'b0;
    new_game_d = 1'b0;

    case (scene_q)
      SCENE_START: begin
        if (enter_rise) begin
          scene_d    = SCENE_PLAY;
          lives_d    = LIVES_INIT;
          new_game_d = 1'b1;
        end
      end

      SCENE_PLAY: begin
        // Clearing the last dot wins even if a ghost is touched in that same cycle
        if (dots_clear) begin
          scene_d = SCENE_WIN;
        end else if (any_hit && !powered) begin
          // lives is always >= 1 while playing, so this cannot wrap
          scene_d = SCENE_DYING;
          lives_d = lives_q - 3'd1;
          timer_d = 8'd0;
        end else if (any_hit && powered) begin
          eaten_d = hit;
        end
      end

      SCENE_DYING: begin
        if (death_done) begin
          if (lives_q == 3'd0) begin
            scene_d = SCENE_LOSE;
          end else begin
            scene_d   = SCENE_PLAY;
            respawn_d = 1'b1;
          end
        end else if (bus.tick) begin
          timer_d = timer_q + 8'd1;
        end
      end

      SCENE_WIN, SCENE_LOSE: begin
        // Lives stay as they are here; they reload on the way into PLAY
        if (enter_rise) begin
          scene_d = SCENE_START;
        end
      end

      default: begin
        scene_d = SCENE_START;
      end
    endcase
  end

  // Scene, lives, death timer and output pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scene_q    <= SCENE_START;
      lives_q    <= LIVES_INIT;
      timer_q    <= 8'd0;
      eaten_q    <= '0;
      respawn_q  <= 1'b0;
      new_game_q <= 1'b0;
    end else begin
      scene_q    <= scene_d;
      lives_q    <= lives_d;
      timer_q    <= timer_d;
      eaten_q    <= eaten_d;
      respawn_q  <= respawn_d;
      new_game_q <= new_game_d;
    end
  end

endmodule
